// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block: register map, CTRL bit positions,
// controller state encoding and counter width.
package pwm_pkg;

    localparam int CNT_W = 16;

    // Register addresses on the byte-wide SPI register bus
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_DUTY_L   = 3'd4;
    localparam logic [2:0] ADDR_DUTY_H   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    // CTRL register bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_EXT     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_POL     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/pwm_core_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a rising-edge
// detector; emits a registered one-cycle pulse per rising edge.
// SYNC_STAGES must be at least 2.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer and flag a 0->1 transition
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/pwm_core.sv
// Register-programmable PWM generator: register file written by the SPI
// slave, combinational readback, prescaler, 16-bit counter with shadowed
// period/duty, IDLE/ARMED/RUN/DONE controller and a registered output.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       ext_start,
    output logic       pwm_out,
    output logic       busy
);

    logic [3:0]       ctrl_q;
    logic [7:0]       prescale_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] duty_q;

    pwm_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       presc_cnt;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh;

    logic             ext_pulse;
    logic             tick;
    logic             en;

    assign en   = ctrl_q[CTRL_EN];
    assign tick = (presc_cnt == prescale_q);
    assign busy = (state == ARMED) || (state == RUN);

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_start),
        .pulse    (ext_pulse)
    );

    // Register file: byte writes land on the strobe edge; STATUS and 7 ignore writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            period_q   <= '0;
            duty_q     <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_CTRL:     ctrl_q           <= wr_data[3:0];
                ADDR_PRESCALE: prescale_q       <= wr_data;
                ADDR_PERIOD_L: period_q[7:0]    <= wr_data;
                ADDR_PERIOD_H: period_q[15:8]   <= wr_data;
                ADDR_DUTY_L:   duty_q[7:0]      <= wr_data;
                ADDR_DUTY_H:   duty_q[15:8]     <= wr_data;
                default:       ;
            endcase
        end
    end

    // Zero-latency readback; STATUS is decoded from the registered state
    // NOTE: rd_data gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_CTRL:     rd_data = {4'b0, ctrl_q};
            ADDR_PRESCALE: rd_data = prescale_q;
            ADDR_PERIOD_L: rd_data = period_q[7:0];
            ADDR_PERIOD_H: rd_data = period_q[15:8];
            ADDR_DUTY_L:   rd_data = duty_q[7:0];
            ADDR_DUTY_H:   rd_data = duty_q[15:8];
            ADDR_STATUS:   rd_data = {5'b0, state == DONE, state == ARMED, state == RUN};
            default:       rd_data = '0;
        endcase
    end

    // Controller, prescaler, counter and shadow registers; clearing EN wins over all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            presc_cnt <= '0;
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (!en) begin
            state     <= IDLE;
            cnt       <= '0;
            presc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_q[CTRL_EXT]) begin
                        state <= ARMED;
                    end else begin
                        state     <= RUN;
                        cnt       <= '0;
                        presc_cnt <= '0;
                        period_sh <= period_q;
                        duty_sh   <= duty_q;
                    end
                end
                ARMED: begin
                    if (ext_pulse) begin
                        state     <= RUN;
                        cnt       <= '0;
                        presc_cnt <= '0;
                        period_sh <= period_q;
                        duty_sh   <= duty_q;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_cnt <= '0;
                        if (cnt == period_sh) begin
                            cnt <= '0;
                            if (ctrl_q[CTRL_ONESHOT]) begin
                                state <= DONE;
                            end else begin
                                // Continuous mode picks up new values only at wrap
                                period_sh <= period_q;
                                duty_sh   <= duty_q;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        presc_cnt <= presc_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Parked until software clears EN
                    presc_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output flop: active level only while running and below the duty threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= ctrl_q[CTRL_POL] ^ ((state == RUN) && (cnt < duty_sh));
        end
    end

endmodule

// File: tb/tb_pwm_core.sv
// Self-checking bench for pwm_core: randomized PWM configurations compared
// cycle-by-cycle against a waveform model built from period/duty arithmetic.
module tb_pwm_core;
    import pwm_pkg::*;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       ext_start = 1'b0;
    logic       pwm_out;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    pwm_core #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ext_start (ext_start),
        .pwm_out   (pwm_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        rd_addr = a; #1;
        d = rd_data;
    endtask

    task automatic program_regs(input int presc, input int per, input int duty);
        write_reg(ADDR_PRESCALE, 8'(presc));
        write_reg(ADDR_PERIOD_L, 8'(per));
        write_reg(ADDR_PERIOD_H, 8'(per >> 8));
        write_reg(ADDR_DUTY_L,   8'(duty));
        write_reg(ADDR_DUTY_H,   8'(duty >> 8));
    endtask

    task automatic stop_pwm();
        write_reg(ADDR_CTRL, 8'h00);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reference waveform: each period has PERIOD+1 counter steps, each lasting
    // PRESCALE+1 cycles; the output is active on steps below DUTY.
    task automatic add_periods(input int presc, input int per, input int duty,
                               input bit pol, input int nper);
        for (int p = 0; p < nper; p++)
            for (int t = 0; t <= per; t++)
                for (int c = 0; c <= presc; c++)
                    exp_q.push_back(pol ^ (t < duty));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", a, d); end
        end
    endtask

    task automatic test_readback();
        logic [7:0] d;
        logic [7:0] vals [6];
        vals[0] = 8'(($urandom_range(0, 15) << 4) | ($urandom_range(0, 7) << 1)); // EN kept 0
        for (int i = 1; i < 6; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) write_reg(3'(i), vals[i]);
        write_reg(ADDR_STATUS, 8'hFF);
        write_reg(3'd7, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want;
            want = (i == 0) ? {4'b0, vals[0][3:0]} : (i < 6) ? vals[i] : 8'h00;
            read_reg(3'(i), d);
            checks++;
            if (d !== want) begin errors++; $display("FAIL readback_reg%0d: got %h want %h", i, d, want); end
        end
        stop_pwm();
    endtask

    // Enables with the given config and compares every cycle to the model.
    task automatic run_wave(input string name, input int presc, input int per,
                            input int duty, input bit pol, input int nper);
        program_regs(presc, per, duty);
        exp_q.delete();
        add_periods(presc, per, duty, pol, nper);
        write_reg(ADDR_CTRL, {4'(pol) << CTRL_POL} | 8'h01);
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            checks++;
            if (pwm_out !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d (ps=%0d per=%0d duty=%0d pol=%0d): got %b want %b",
                         name, i, presc, per, duty, pol, pwm_out, exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, busy); end
        stop_pwm();
    endtask

    task automatic test_continuous();
        run_wave("cont_basic", 0, 9, 3, 1'b0, 3);
        run_wave("prescale_pol", 1, 3, 1, 1'b1, 3);
        for (int k = 0; k < 6; k++)
            run_wave("cont_rand", $urandom_range(0, 3), $urandom_range(0, 12),
                     $urandom_range(0, 15), 1'($urandom), 3);
    endtask

    task automatic test_edge_cases();
        run_wave("duty_zero", 1, 5, 0, 1'($urandom), 2);
        run_wave("duty_full", 0, 5, 6, 1'b0, 2);
        run_wave("period_zero", 2, 0, 1, 1'b0, 4);
        run_wave("period_zero_duty0", 0, 0, 0, 1'b1, 4);
    endtask

    task automatic test_shadow();
        program_regs(0, 9, 3);
        exp_q.delete();
        add_periods(0, 9, 3, 1'b0, 1);
        add_periods(0, 9, 7, 1'b0, 2);
        write_reg(ADDR_CTRL, 8'h01);
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            if (i == 5) wr_en = 1'b0;
            checks++;
            if (pwm_out !== exp_q[i]) begin
                errors++;
                $display("FAIL shadow cycle %0d: got %b want %b", i, pwm_out, exp_q[i]);
            end
            if (i == 4) begin
                wr_en = 1'b1; wr_addr = ADDR_DUTY_L; wr_data = 8'd7;
            end
        end
        stop_pwm();
    endtask

    task automatic test_ext_start();
        logic [7:0] d;
        int wait_cyc;
        // Edge while IDLE must not carry over into a later arm
        @(negedge clk); ext_start = 1'b1;
        repeat (SYNC + 3) @(posedge clk);
        @(negedge clk); ext_start = 1'b0;
        repeat (SYNC + 3) @(posedge clk);
        program_regs(0, 5, 2);
        write_reg(ADDR_CTRL, 8'h03);
        @(posedge clk); #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL ext_armed: status %h want 02", d); end
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL ext_idle_pwm: got %b want 0", pwm_out); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ext_busy: got %b want 1", busy); end
        wait_cyc = $urandom_range(1, 5);
        repeat (wait_cyc) @(posedge clk);
        #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL ext_still_armed: status %h want 02", d); end
        // Pulse: sampled at edge K, still ARMED after K+SYNC, RUN after K+SYNC+1
        @(negedge clk); ext_start = 1'b1;
        for (int i = 0; i <= SYNC; i++) @(posedge clk);
        #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL ext_latency_early: status %h want 02", d); end
        @(posedge clk); #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL ext_run: status %h want 01", d); end
        @(posedge clk); #1;
        checks++;
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL ext_first_pwm: got %b want 1", pwm_out); end
        @(negedge clk); ext_start = 1'b0;
        stop_pwm();
        // Synced edge arriving together with EN=0 is discarded
        write_reg(ADDR_CTRL, 8'h03);
        repeat (3) @(posedge clk);
        @(negedge clk); ext_start = 1'b1;
        repeat (SYNC) @(posedge clk);
        write_reg(ADDR_CTRL, 8'h00);
        @(posedge clk); #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ext_discard: status %h want 00", d); end
        repeat (3) @(posedge clk);
        #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ext_discard_hold: status %h want 00", d); end
        @(negedge clk); ext_start = 1'b0;
        stop_pwm();
    endtask

    task automatic test_oneshot();
        logic [7:0] d;
        int presc;
        presc = $urandom_range(0, 2);
        program_regs(presc, 4, 9);
        exp_q.delete();
        add_periods(presc, 4, 9, 1'b0, 1);
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
        write_reg(ADDR_CTRL, 8'h05);
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            checks++;
            if (pwm_out !== exp_q[i]) begin
                errors++;
                $display("FAIL oneshot cycle %0d (ps=%0d): got %b want %b", i, presc, pwm_out, exp_q[i]);
            end
        end
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h04) begin errors++; $display("FAIL oneshot_done: status %h want 04", d); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy: got %b want 0", busy); end
        // Rewriting EN while DONE does not restart
        write_reg(ADDR_CTRL, 8'h05);
        @(posedge clk); #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h04) begin errors++; $display("FAIL oneshot_no_rearm: status %h want 04", d); end
        stop_pwm();
        write_reg(ADDR_CTRL, 8'h05);
        @(posedge clk); #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL oneshot_rearm: status %h want 01", d); end
        stop_pwm();
    endtask

    task automatic test_abort_reset();
        logic [7:0] d;
        program_regs(0, 9, 5);
        write_reg(ADDR_CTRL, 8'h09);
        repeat (4) @(posedge clk);
        write_reg(ADDR_CTRL, 8'h08);
        @(posedge clk); #1;
        read_reg(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL abort_idle: status %h want 00", d); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL abort_pwm: got %b want 1", pwm_out); end
        // Reset mid-run with POL=1 and an active phase
        write_reg(ADDR_CTRL, 8'h09);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL rst_reg%0d: got %h want 00", a, d); end
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_release_pwm: got %b want 0", pwm_out); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_readback();
        test_continuous();
        test_edge_cases();
        test_shadow();
        test_ext_start();
        test_oneshot();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
